// File: rtl/eth_tx_arb_if.sv
// Signal bundle for the Ethernet TX arbiter: the packed per-source frame inputs
// and the single merged frame output.
interface eth_tx_arb_if #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 8
);
  logic [S_COUNT-1:0]            s_eth_hdr_valid;
  logic [S_COUNT-1:0]            s_eth_hdr_ready;
  logic [S_COUNT*48-1:0]         s_eth_dest_mac;
  logic [S_COUNT*48-1:0]         s_eth_src_mac;
  logic [S_COUNT*16-1:0]         s_eth_type;
  logic [S_COUNT*DATA_WIDTH-1:0] s_eth_payload_axis_tdata;
  logic [S_COUNT-1:0]            s_eth_payload_axis_tvalid;
  logic [S_COUNT-1:0]            s_eth_payload_axis_tlast;
  logic [S_COUNT-1:0]            s_eth_payload_axis_tuser;
  logic [S_COUNT-1:0]            s_eth_payload_axis_tready;

  logic                          m_eth_hdr_valid;
  logic                          m_eth_hdr_ready;
  logic [47:0]                   m_eth_dest_mac;
  logic [47:0]                   m_eth_src_mac;
  logic [15:0]                   m_eth_type;
  logic [DATA_WIDTH-1:0]         m_eth_payload_axis_tdata;
  logic                          m_eth_payload_axis_tvalid;
  logic                          m_eth_payload_axis_tlast;
  logic                          m_eth_payload_axis_tuser;
  logic                          m_eth_payload_axis_tready;

  // slave is the arbiter's view; master is the surrounding sources and sink
  modport slave (
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
           s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
           s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
           m_eth_hdr_ready, m_eth_payload_axis_tready,
    output s_eth_hdr_ready, s_eth_payload_axis_tready,
           m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
           m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
           m_eth_payload_axis_tlast, m_eth_payload_axis_tuser
  );

  modport master (
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
           s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
           s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
           m_eth_hdr_ready, m_eth_payload_axis_tready,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready,
           m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
           m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
           m_eth_payload_axis_tlast, m_eth_payload_axis_tuser
  );
endinterface

// File: rtl/eth_tx_arb.sv
// Round-robin, frame-granular arbiter merging S_COUNT Ethernet frame sources
// (header + AXI-stream payload) onto one output; a grant lasts until payload tlast.
module eth_tx_arb #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  eth_tx_arb_if.slave                bus,
  output logic                       busy,
  output logic [$clog2(S_COUNT)-1:0] grant_index
);
  localparam int IDX_W = $clog2(S_COUNT);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr, sel_idx, hi_idx, any_idx;
  logic                  sel_found, hi_found;
  logic [47:0]           dest_mac_q, src_mac_q, sel_dest, sel_src;
  logic [15:0]           type_q, sel_type;
  logic [DATA_WIDTH-1:0] g_tdata;
  logic                  g_tvalid, g_tlast, g_tuser;
  logic                  last_hs;

  // Lowest requesting index at or above rr_ptr wins, otherwise lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    any_idx  = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (bus.s_eth_hdr_valid[i]) begin
        any_idx = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    sel_found = |bus.s_eth_hdr_valid;
    sel_idx   = hi_found ? hi_idx : any_idx;
  end

  always_comb begin
    sel_dest = '0;
    sel_src  = '0;
    sel_type = '0;
    g_tdata  = '0;
    g_tvalid = 1'b0;
    g_tlast  = 1'b0;
    g_tuser  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_dest = bus.s_eth_dest_mac[i*48 +: 48];
        sel_src  = bus.s_eth_src_mac[i*48 +: 48];
        sel_type = bus.s_eth_type[i*16 +: 16];
      end
      if (grant_index == IDX_W'(i)) begin
        g_tdata  = bus.s_eth_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        g_tvalid = bus.s_eth_payload_axis_tvalid[i];
        g_tlast  = bus.s_eth_payload_axis_tlast[i];
        g_tuser  = bus.s_eth_payload_axis_tuser[i];
      end
    end
  end

  assign last_hs = (state == PAYLOAD) && g_tvalid && g_tlast && bus.m_eth_payload_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found)           state_nxt = HDR;
      HDR:     if (bus.m_eth_hdr_ready) state_nxt = PAYLOAD;
      PAYLOAD: if (last_hs)             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Readies and payload valid are forced low while rst_n is asserted.
  always_comb begin
    bus.s_eth_hdr_ready           = '0;
    bus.s_eth_payload_axis_tready = '0;
    bus.m_eth_payload_axis_tdata  = g_tdata;
    bus.m_eth_payload_axis_tvalid = 1'b0;
    bus.m_eth_payload_axis_tlast  = 1'b0;
    bus.m_eth_payload_axis_tuser  = 1'b0;
    bus.m_eth_hdr_valid           = (state == HDR);
    busy                          = (state != IDLE);
    if (rst_n && state == IDLE && sel_found)
      bus.s_eth_hdr_ready[sel_idx] = 1'b1;
    if (rst_n && state == PAYLOAD) begin
      bus.s_eth_payload_axis_tready[grant_index] = bus.m_eth_payload_axis_tready;
      bus.m_eth_payload_axis_tvalid = g_tvalid;
      bus.m_eth_payload_axis_tlast  = g_tlast;
      bus.m_eth_payload_axis_tuser  = g_tuser;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant_index <= '0;
      dest_mac_q  <= '0;
      src_mac_q   <= '0;
      type_q      <= '0;
    end else begin
      if (state == IDLE && sel_found) begin
        grant_index <= sel_idx;
        dest_mac_q  <= sel_dest;
        src_mac_q   <= sel_src;
        type_q      <= sel_type;
      end
      if (last_hs)
        rr_ptr <= (grant_index == IDX_W'(S_COUNT - 1)) ? '0 : grant_index + 1'b1;
    end
  end

  assign bus.m_eth_dest_mac = dest_mac_q;
  assign bus.m_eth_src_mac  = src_mac_q;
  assign bus.m_eth_type     = type_q;
endmodule
